// File: rtl/alu_exec_unit.sv
// -----------------------------------------------------------------------------
// alu_exec_unit
//
// Integer execution unit with a MIPS-style R-type function decoder.
// Single-cycle ops (add/sub/logic/slt/mfhi/mflo) complete in the cycle after
// they are accepted. multu and divu run iteratively for WIDTH cycles, using
// the HI/LO pair as the working accumulator (shift-add multiply, restoring
// divide).
//
// Ports
//   clk      : clock, all state updates on rising edge
//   rst      : asynchronous active-high reset
//   start    : operation request, accepted only while idle
//   alu_op   : 0 = add, 1 = subtract, 2/3 = decode func
//   func     : R-type function code (used when alu_op >= 2)
//   a, b     : operands, captured at accept
//   result   : registered result of last completed single-cycle op
//   zero     : registered, high when result == 0
//   busy     : high while multu/divu is iterating
//   done     : one-cycle completion pulse for every accepted op
//   illegal  : one-cycle pulse alongside done for an undefined func
//   hi, lo   : HI/LO registers (intermediate values while busy)
// -----------------------------------------------------------------------------
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] opnd_q;     // multiplicand (multu) or divisor (divu)
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic             illegal_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // ------------------------------------------------------------------
    // Decode of the single-cycle result and the multi-cycle launches
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] dec_res;
    logic             dec_ill;
    logic             dec_mul;
    logic             dec_div;

    always_comb begin
        dec_res = '0;
        dec_ill = 1'b0;
        dec_mul = 1'b0;
        dec_div = 1'b0;
        if (alu_op == 2'd0) begin
            dec_res = a + b;
        end else if (alu_op == 2'd1) begin
            dec_res = a - b;
        end else begin
            case (func)
                6'd32, 6'd33: dec_res = a + b;
                6'd34, 6'd35: dec_res = a - b;
                6'd36:        dec_res = a & b;
                6'd37:        dec_res = a | b;
                6'd38:        dec_res = a ^ b;
                6'd39:        dec_res = ~(a | b);
                6'd42:        dec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                6'd43:        dec_res = {{(WIDTH-1){1'b0}}, (a < b)};
                6'd16:        dec_res = hi_q;
                6'd18:        dec_res = lo_q;
                6'd25:        dec_mul = 1'b1;
                6'd27:        dec_div = 1'b1;
                default:      dec_ill = 1'b1;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // One iteration of each multi-cycle algorithm
    // ------------------------------------------------------------------
    // Multiply: LO starts as the multiplier; its LSB selects whether the
    // multiplicand is added into HI, then {carry,HI,LO} shifts right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_d;
    logic [WIDTH-1:0] mul_lo_d;
    // Divide: LO starts as the dividend and shifts quotient bits in from
    // the right while HI accumulates the partial remainder.
    logic [WIDTH:0]   div_rem;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_d;
    logic [WIDTH-1:0] div_lo_d;

    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_d = mul_sum[WIDTH:1];
        mul_lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};

        div_rem  = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_rem - {1'b0, opnd_q};
        div_ge   = (div_rem >= {1'b0, opnd_q});
        // A zero divisor always "fits", giving an all-ones quotient and
        // leaving the dividend in HI after WIDTH steps.
        div_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_rem[WIDTH-1:0];
        div_lo_d = {lo_q[WIDTH-2:0], div_ge};
    end

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            opnd_q    <= '0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (dec_mul) begin
                            state_q <= S_MUL;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            opnd_q  <= a;
                            hi_q    <= '0;
                            lo_q    <= b;
                        end else if (dec_div) begin
                            state_q <= S_DIV;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                            opnd_q  <= b;
                            hi_q    <= '0;
                            lo_q    <= a;
                        end else begin
                            result_q  <= dec_res;
                            zero_q    <= (dec_res == '0);
                            done_q    <= 1'b1;
                            illegal_q <= dec_ill;
                        end
                    end
                end
                S_MUL: begin
                    hi_q <= mul_hi_d;
                    lo_q <= mul_lo_d;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    hi_q <= div_hi_d;
                    lo_q <= div_lo_d;
                    if (cnt_q == LAST_STEP) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign result  = result_q;
    assign zero    = zero_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_alu_exec_unit
//
// Self-checking bench: a 32-bit instance driven by a constant vector table,
// hand sequences for the multi-cycle corner cases and a randomized run
// against an arithmetic reference model; an 8-bit instance covers the
// narrow-datapath divide cases.
// -----------------------------------------------------------------------------
module tb_alu_exec_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        st = 1'b0;
    logic [1:0]  op = '0;
    logic [5:0]  fn = '0;
    logic [31:0] ra = '0, rb = '0;
    logic [31:0] res, hiw, low;
    logic        zr, bsy, dn, ill;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(st), .alu_op(op), .func(fn),
        .a(ra), .b(rb), .result(res), .zero(zr), .busy(bsy),
        .done(dn), .illegal(ill), .hi(hiw), .lo(low)
    );

    // 8-bit instance
    logic       st8 = 1'b0;
    logic [1:0] op8 = '0;
    logic [5:0] fn8 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] res8, hi8, lo8;
    logic       zr8, bsy8, dn8, ill8;

    alu_exec_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .alu_op(op8), .func(fn8),
        .a(a8), .b(b8), .result(res8), .zero(zr8), .busy(bsy8),
        .done(dn8), .illegal(ill8), .hi(hi8), .lo(lo8)
    );

    int checks = 0;
    int errors = 0;

    // Reference state of the 32-bit instance
    logic [31:0] model_hi  = '0;
    logic [31:0] model_lo  = '0;
    logic [31:0] model_res = '0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference behaviour of single-cycle ops: returns {illegal, result}
    function automatic logic [32:0] ref_single(input logic [1:0] o, input logic [5:0] f,
                                               input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        il;
        r  = '0;
        il = 1'b0;
        if (o == 2'd0)      r = x + y;
        else if (o == 2'd1) r = x - y;
        else begin
            case (f)
                6'd32, 6'd33: r = x + y;
                6'd34, 6'd35: r = x - y;
                6'd36: r = x & y;
                6'd37: r = x | y;
                6'd38: r = x ^ y;
                6'd39: r = ~(x | y);
                6'd42: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
                6'd43: r = (x < y) ? 32'd1 : 32'd0;
                6'd16: r = model_hi;
                6'd18: r = model_lo;
                default: il = 1'b1;
            endcase
        end
        return {il, r};
    endfunction

    task automatic apply_single(input logic [1:0] o, input logic [5:0] f,
                                input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] exp_res, input logic exp_ill,
                                input string nm);
        @(negedge clk);
        op = o; fn = f; ra = x; rb = y; st = 1'b1;
        @(posedge clk); #1;
        check({nm, "_result"}, 64'(res), 64'(exp_res));
        check({nm, "_zero"}, 64'(zr), 64'(exp_res == 32'd0));
        check({nm, "_done"}, 64'(dn), 64'd1);
        check({nm, "_illegal"}, 64'(ill), 64'(exp_ill));
        check({nm, "_hi"}, 64'(hiw), 64'(model_hi));
        check({nm, "_lo"}, 64'(low), 64'(model_lo));
        check({nm, "_busy"}, 64'(bsy), 64'd0);
        @(negedge clk);
        st = 1'b0;
        @(posedge clk); #1;
        check({nm, "_done_drop"}, 64'(dn), 64'd0);
        check({nm, "_illegal_drop"}, 64'(ill), 64'd0);
        model_res = exp_res;
        $display("single %s op=%0d func=%0d a=%h b=%h result=%h illegal=%0b",
                 nm, o, f, x, y, res, ill);
    endtask

    task automatic run_multi(input logic [5:0] f, input logic [31:0] x,
                             input logic [31:0] y, input string nm);
        logic [63:0] prod;
        logic [31:0] exp_hi, exp_lo;
        int          cycles, busy_bad;
        bit          got;
        if (f == 6'd25) begin
            prod   = 64'(x) * 64'(y);
            exp_hi = prod[63:32];
            exp_lo = prod[31:0];
        end else if (y == 32'd0) begin
            exp_hi = x;
            exp_lo = 32'hFFFF_FFFF;
        end else begin
            exp_hi = x % y;
            exp_lo = x / y;
        end
        @(negedge clk);
        op = 2'd2; fn = f; ra = x; rb = y; st = 1'b1;
        @(posedge clk); #1;
        check({nm, "_busy_at_accept"}, 64'(bsy), 64'd1);
        check({nm, "_no_done_at_accept"}, 64'(dn), 64'd0);
        @(negedge clk);
        st = 1'b0;
        ra = $urandom;              // operands must already be captured
        rb = $urandom;
        cycles = 0; busy_bad = 0; got = 1'b0;
        while (!got && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
            if (dn) got = 1'b1;
            else if (!bsy) busy_bad++;
        end
        check({nm, "_latency"}, 64'(cycles), 64'd32);
        check({nm, "_busy_held"}, 64'(busy_bad), 64'd0);
        check({nm, "_busy_low_at_done"}, 64'(bsy), 64'd0);
        check({nm, "_hi"}, 64'(hiw), 64'(exp_hi));
        check({nm, "_lo"}, 64'(low), 64'(exp_lo));
        check({nm, "_result_kept"}, 64'(res), 64'(model_res));
        check({nm, "_illegal"}, 64'(ill), 64'd0);
        model_hi = exp_hi;
        model_lo = exp_lo;
        $display("multi %s func=%0d a=%h b=%h hi=%h lo=%h cycles=%0d",
                 nm, f, x, y, hiw, low, cycles);
    endtask

    task automatic run_multi8(input logic [5:0] f, input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                              input string nm);
        int cycles;
        bit got;
        @(negedge clk);
        op8 = 2'd3; fn8 = f; a8 = x; b8 = y; st8 = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        st8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        cycles = 0; got = 1'b0;
        while (!got && cycles < 20) begin
            @(posedge clk); #1;
            cycles++;
            if (dn8) got = 1'b1;
        end
        check({nm, "_latency"}, 64'(cycles), 64'd8);
        check({nm, "_hi"}, 64'(hi8), 64'(exp_hi));
        check({nm, "_lo"}, 64'(lo8), 64'(exp_lo));
        $display("multi8 %s func=%0d a=%0d b=%0d hi=%0d lo=%0d cycles=%0d",
                 nm, f, x, y, hi8, lo8, cycles);
    endtask

    typedef struct packed {
        logic [1:0]  o;
        logic [5:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] r;
        logic        il;
    } vec_t;

    vec_t vecs[14];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [5:0]  deflist[12];
        logic [32:0] rr;
        logic [1:0]  ro;
        logic [5:0]  rf;
        logic [31:0] rx, ry;
        int          dones;

        vecs[0]  = '{2'd0, 6'd0,  32'd5,         32'd7,         32'd12,        1'b0};
        vecs[1]  = '{2'd0, 6'd63, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
        vecs[2]  = '{2'd1, 6'd0,  32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
        vecs[3]  = '{2'd2, 6'd42, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0};
        vecs[4]  = '{2'd2, 6'd43, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0};
        vecs[5]  = '{2'd2, 6'd36, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0};
        vecs[6]  = '{2'd3, 6'd37, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
        vecs[7]  = '{2'd2, 6'd38, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0};
        vecs[8]  = '{2'd2, 6'd39, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{2'd2, 6'd35, 32'd10,        32'd10,        32'd0,         1'b0};
        vecs[10] = '{2'd3, 6'd33, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0};
        vecs[11] = '{2'd2, 6'd34, 32'd0,         32'd1,         32'hFFFF_FFFF, 1'b0};
        vecs[12] = '{2'd2, 6'd0,  32'd9,         32'd9,         32'd0,         1'b1};
        vecs[13] = '{2'd3, 6'd42, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1,         1'b0};

        deflist = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37,
                    6'd38, 6'd39, 6'd42, 6'd43, 6'd16, 6'd18};

        // ---------------- reset state ----------------
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", 64'(res), 64'd0);
        check("rst_zero", 64'(zr), 64'd1);
        check("rst_busy", 64'(bsy), 64'd0);
        check("rst_done", 64'(dn), 64'd0);
        check("rst_illegal", 64'(ill), 64'd0);
        check("rst_hi", 64'(hiw), 64'd0);
        check("rst_lo", 64'(low), 64'd0);
        check("rst_lo8", 64'(lo8), 64'd0);
        $display("reset result=%h zero=%0b busy=%0b hi=%h lo=%h", res, zr, bsy, hiw, low);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 14; i++) begin
            apply_single(vecs[i].o, vecs[i].f, vecs[i].x, vecs[i].y,
                         vecs[i].r, vecs[i].il, $sformatf("vec%0d", i));
        end

        // ---------------- multu, mflo, mfhi ----------------
        run_multi(6'd25, 32'hFFFF_FFFF, 32'd2, "multu_ff_2");
        apply_single(2'd2, 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0, "mflo");
        apply_single(2'd2, 6'd16, 32'd0, 32'd0, 32'd1, 1'b0, "mfhi");

        // ---------------- undefined func keeps hi/lo ----------------
        apply_single(2'd2, 6'd63, 32'd1, 32'd2, 32'd0, 1'b1, "illegal63");

        // ---------------- divu with start held every cycle ----------------
        // divu 1000/7 accepted, then an add request held high throughout:
        // only the edge after completion may accept it.
        @(negedge clk);
        op = 2'd2; fn = 6'd27; ra = 32'd1000; rb = 32'd7; st = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        fn = 6'd32; ra = 32'd3; rb = 32'd4;
        dones = 0;
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            if (dn) dones++;
        end
        check("flood_done_count", 64'(dones), 64'd1);
        check("flood_done_at_32", 64'(dn), 64'd1);
        check("flood_result_kept", 64'(res), 64'(model_res));
        check("flood_hi", 64'(hiw), 64'd6);
        check("flood_lo", 64'(low), 64'd142);
        @(posedge clk); #1;
        check("flood_next_accept_done", 64'(dn), 64'd1);
        check("flood_next_accept_result", 64'(res), 64'd7);
        check("flood_next_accept_busy", 64'(bsy), 64'd0);
        @(negedge clk);
        st = 1'b0;
        @(posedge clk); #1;
        check("flood_done_drop", 64'(dn), 64'd0);
        model_hi = 32'd6; model_lo = 32'd142; model_res = 32'd7;
        $display("flood divu 1000/7 hi=%0d lo=%0d result=%0d dones=%0d", hiw, low, res, dones);

        // ---------------- randomized run ----------------
        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            rf = ($urandom_range(0, 1) == 1) ? deflist[$urandom_range(0, 11)]
                                              : 6'($urandom_range(0, 63));
            case ($urandom_range(0, 3))
                0:       rx = 32'hFFFF_FFFF;
                1:       rx = 32'($urandom_range(0, 3));
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       ry = 32'd0;
                1:       ry = 32'($urandom_range(1, 9));
                default: ry = $urandom;
            endcase
            if (ro >= 2'd2 && (rf == 6'd25 || rf == 6'd27) && ($urandom_range(0, 3) == 0)) begin
                run_multi(rf, rx, ry, $sformatf("rnd%0d", i));
            end else begin
                if (ro >= 2'd2 && (rf == 6'd25 || rf == 6'd27)) ro = 2'd0;
                rr = ref_single(ro, rf, rx, ry);
                apply_single(ro, rf, rx, ry, rr[31:0], rr[32], $sformatf("rnd%0d", i));
            end
        end
        run_multi(6'd27, $urandom, 32'd0, "divu_zero32");
        run_multi(6'd27, $urandom, $urandom_range(1, 1000), "divu_rnd32");

        // ---------------- reset in the middle of multu ----------------
        @(negedge clk);
        op = 2'd2; fn = 6'd25; ra = 32'h1234_5678; rb = 32'h9ABC_DEF0; st = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        st = 1'b0;
        dones = 0;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk); #1;
            if (dn) dones++;
        end
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(bsy), 64'd0);
        check("midrst_hi", 64'(hiw), 64'd0);
        check("midrst_lo", 64'(low), 64'd0);
        check("midrst_result", 64'(res), 64'd0);
        check("midrst_zero", 64'(zr), 64'd1);
        @(posedge clk); #1;
        if (dn) dones++;
        check("midrst_no_done", 64'(dones), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_hi = '0; model_lo = '0; model_res = '0;
        op = 2'd0; fn = 6'd0; ra = 32'd3; rb = 32'd4; st = 1'b1;
        @(posedge clk); #1;
        check("postrst_add_done", 64'(dn), 64'd1);
        check("postrst_add_result", 64'(res), 64'd7);
        check("postrst_hi", 64'(hiw), 64'd0);
        @(negedge clk);
        st = 1'b0;
        $display("midreset abandoned multu, add 3+4 result=%0d", res);

        // ---------------- 8-bit divide cases ----------------
        run_multi8(6'd27, 8'd200, 8'd7, 8'd4, 8'd28, "divu8_200_7");
        run_multi8(6'd27, 8'd200, 8'd0, 8'd200, 8'hFF, "divu8_200_0");
        run_multi8(6'd25, 8'd255, 8'd255, 8'hFE, 8'h01, "multu8_ff_ff");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
